// File: rtl/reflet_ram_responder.sv
// rtl/reflet_ram_responder.sv - word-wide RAM responder for the Reflet CPU bus
// One-cycle read latency, write-first, with out-of-range flagging and write-fault diagnostics.
module reflet_ram_responder #(
  parameter int wordsize  = 16,
  parameter int size      = 1024,
  parameter int base_addr = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                out_of_range,
  output logic                write_fault,
  output logic [wordsize-1:0] fault_addr,
  output logic [7:0]          fault_count,
  input  logic                fault_clear
);

  localparam int bytes = wordsize / 8;
  localparam int shift = $clog2(bytes);
  localparam int depth = size / bytes;
  localparam int aw    = (depth > 1) ? $clog2(depth) : 1;

  // One extra bit so the range test never wraps around.
  localparam logic [wordsize:0] base_ext = (wordsize + 1)'(base_addr);
  localparam logic [wordsize:0] size_ext = (wordsize + 1)'(size);

  logic [wordsize-1:0] mem [depth];

  logic [wordsize:0] offset;
  logic [wordsize:0] word_off;
  logic [aw-1:0]     idx;
  logic              in_range;
  logic              mem_we;
  logic              fault_hit;
  logic              unused_word_off;

  assign offset          = {1'b0, addr} - base_ext;
  assign in_range        = ({1'b0, addr} >= base_ext) && (offset < size_ext);
  assign word_off        = offset >> shift;
  assign idx             = word_off[aw-1:0];
  assign unused_word_off = ^word_off[wordsize:aw];

  assign mem_we    = enable && !reset && write_en && in_range;
  assign fault_hit = write_en && !in_range;

  // Memory and read register share one process so it maps onto write-first block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= data_in;
    end
    if (reset) begin
      data_out     <= '0;
      out_of_range <= 1'b0;
    end else if (enable) begin
      out_of_range <= !in_range;
      if (!in_range) begin
        data_out <= '0;
      end else if (write_en) begin
        data_out <= data_in;
      end else begin
        data_out <= mem[idx];
      end
    end
  end

  // A faulted write in the same cycle as fault_clear restarts the record from this fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_fault <= 1'b0;
      fault_addr  <= '0;
      fault_count <= '0;
    end else if (enable) begin
      if (fault_hit) begin
        write_fault <= 1'b1;
        if (fault_clear) begin
          fault_count <= 8'd1;
        end else if (fault_count != 8'hFF) begin
          fault_count <= fault_count + 8'd1;
        end
        if (fault_clear || !write_fault) begin
          fault_addr <= addr;
        end
      end else if (fault_clear) begin
        write_fault <= 1'b0;
        fault_addr  <= '0;
        fault_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reflet_ram_responder.sv
// tb/tb_reflet_ram_responder.sv - table-driven bench for reflet_ram_responder
// Window 0x0100..0x04FF, 16-bit words; each row lists inputs and the registered outputs after one edge.
module tb_reflet_ram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic        write_en = 1'b0;
  logic        fault_clear = 1'b0;
  logic [15:0] data_out;
  logic        out_of_range;
  logic        write_fault;
  logic [15:0] fault_addr;
  logic [7:0]  fault_count;

  int total  = 0;
  int passed = 0;
  int row    = 0;

  reflet_ram_responder #(
    .wordsize (16),
    .size     (1024),
    .base_addr(16'h0100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .addr        (addr),
    .data_in     (data_in),
    .write_en    (write_en),
    .data_out    (data_out),
    .out_of_range(out_of_range),
    .write_fault (write_fault),
    .fault_addr  (fault_addr),
    .fault_count (fault_count),
    .fault_clear (fault_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        we;
    logic        clr;
    logic [15:0] a;
    logic [15:0] d;
    bit          chk;
    logic [15:0] e_dout;
    logic        e_oor;
    logic        e_wf;
    logic [15:0] e_fa;
    logic [7:0]  e_fc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic en, logic we, logic clr, logic [15:0] a,
                              logic [15:0] d, bit chk, logic [15:0] e_dout, logic e_oor,
                              logic e_wf, logic [15:0] e_fa, logic [7:0] e_fc);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.clr = clr; v.a = a; v.d = d; v.chk = chk;
    v.e_dout = e_dout; v.e_oor = e_oor; v.e_wf = e_wf; v.e_fa = e_fa; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL row %0d %s: got %0h expected %0h", row, nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic run_vec(vec_t v);
    @(negedge clk);
    reset = v.rst; enable = v.en; write_en = v.we; fault_clear = v.clr;
    addr = v.a; data_in = v.d;
    @(posedge clk);
    #1;
    if (v.chk) begin
      check("data_out", 32'(data_out), 32'(v.e_dout));
      check("out_of_range", 32'(out_of_range), 32'(v.e_oor));
      check("write_fault", 32'(write_fault), 32'(v.e_wf));
      check("fault_addr", 32'(fault_addr), 32'(v.e_fa));
      check("fault_count", 32'(fault_count), 32'(v.e_fc));
    end
    row++;
  endtask

  task automatic apply(logic rst, logic en, logic we, logic clr, logic [15:0] a, logic [15:0] d,
                       logic [15:0] e_dout, logic e_oor, logic e_wf, logic [15:0] e_fa,
                       logic [7:0] e_fc);
    run_vec(mk(rst, en, we, clr, a, d, 1'b1, e_dout, e_oor, e_wf, e_fa, e_fc));
  endtask

  initial begin
    // reset, aligned/unaligned reads, read-during-write
    vq.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 1, 0, 16'h0102, 16'hBEEF, 1, 16'hBEEF, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 0, 0, 16'h0102, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 0, 0, 16'h0102, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 0, 0, 16'h0103, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 1, 0, 16'h0104, 16'h1234, 1, 16'h1234, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 0, 0, 16'h0104, 16'h0000, 1, 16'h1234, 0, 0, 16'h0000, 0));
    // window boundaries
    vq.push_back(mk(0, 1, 1, 0, 16'h04FE, 16'hA5A5, 1, 16'hA5A5, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 1, 0, 16'h0100, 16'h0101, 1, 16'h0101, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 1, 0, 16'h03FE, 16'h3E3E, 1, 16'h3E3E, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 1, 0, 16'h0500, 16'h5A5A, 1, 16'h0000, 1, 1, 16'h0500, 1));
    vq.push_back(mk(0, 1, 0, 0, 16'h04FE, 16'h0000, 1, 16'hA5A5, 0, 1, 16'h0500, 1));
    vq.push_back(mk(0, 1, 0, 0, 16'h00FE, 16'h0000, 1, 16'h0000, 1, 1, 16'h0500, 1));
    vq.push_back(mk(0, 1, 0, 0, 16'h00FF, 16'h0000, 1, 16'h0000, 1, 1, 16'h0500, 1));
    vq.push_back(mk(0, 1, 0, 0, 16'h0100, 16'h0000, 1, 16'h0101, 0, 1, 16'h0500, 1));
    vq.push_back(mk(0, 1, 0, 0, 16'h04FF, 16'h0000, 1, 16'hA5A5, 0, 1, 16'h0500, 1));
    // clear, then first-fault capture and saturation
    vq.push_back(mk(0, 1, 0, 1, 16'h0102, 16'h0000, 1, 16'hBEEF, 0, 0, 16'h0000, 0));
    vq.push_back(mk(0, 1, 1, 0, 16'h0600, 16'hDEAD, 1, 16'h0000, 1, 1, 16'h0600, 1));
    for (int k = 1; k <= 299; k++) begin
      vq.push_back(mk(0, 1, 1, 0, 16'hFFFE, 16'hDEAD, (k == 200 || k == 254 || k == 299),
                      16'h0000, 1, 1, 16'h0600, 8'((k + 1 > 255) ? 255 : k + 1)));
    end
    vq.push_back(mk(0, 1, 0, 0, 16'h03FE, 16'h0000, 1, 16'h3E3E, 0, 1, 16'h0600, 255));

    foreach (vq[i]) run_vec(vq[i]);

    // enable low freezes everything; reset suppresses the write and zeroes outputs
    apply(0, 1, 1, 0, 16'h0110, 16'h1111, 16'h1111, 0, 1, 16'h0600, 255);
    apply(0, 0, 1, 1, 16'h0104, 16'h7777, 16'h1111, 0, 1, 16'h0600, 255);
    apply(0, 1, 0, 0, 16'h0104, 16'h0000, 16'h1234, 0, 1, 16'h0600, 255);
    apply(1, 1, 1, 1, 16'h0110, 16'h7777, 16'h0000, 0, 0, 16'h0000, 0);
    apply(0, 1, 0, 0, 16'h0110, 16'h0000, 16'h1111, 0, 0, 16'h0000, 0);

    // clear colliding with a faulted write
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 1, 0, 16'h0900, 16'h0000, 16'h0000, 1, 1, 16'h0900, 8'(i + 1));
    end
    apply(0, 0, 1, 1, 16'h0A00, 16'h0000, 16'h0000, 1, 1, 16'h0900, 5);
    apply(0, 1, 1, 1, 16'h0800, 16'h0000, 16'h0000, 1, 1, 16'h0800, 1);
    apply(0, 1, 0, 1, 16'h0104, 16'h0000, 16'h1234, 0, 0, 16'h0000, 0);
    apply(0, 1, 0, 0, 16'h00FE, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0);
    apply(0, 1, 1, 0, 16'h0A00, 16'h0000, 16'h0000, 1, 1, 16'h0A00, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
